// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// glyph table (active-high {a..g}), blank pattern and index width helper.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry h holds the lit segments {a,b,c,d,e,f,g} for hex digit h.
  localparam logic [15:0][6:0] GLYPH_ON = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_hex_glyph.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
module seg_hex_glyph
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = ~GLYPH_ON[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous display update.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DW-1:0]         disp_val;
  logic [DW-1:0]         pend_val;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pending_valid;

  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            nibble;
  logic                  dp_sel;
  logic                  lit;
  logic                  blank;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign slot_end = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (idx == IW'(NUM_DIGITS - 1));
  assign nibble   = disp_val[4*idx +: 4];
  assign dp_sel   = disp_dp[idx];
  assign blank    = (int'(cnt) < BLANK_CYC);

`ifdef SEVSEG_LZB_EN
  // A digit stays lit if it or any more significant nibble is nonzero.
  always_comb begin
    lit = (idx == '0) || dp_sel;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (disp_val[4*i +: 4] != 4'h0)) lit = 1'b1;
    end
  end
`else
  assign lit = 1'b1;
`endif

  assign an_next = (blank || !lit) ? '1 : ~(NUM_DIGITS'(1) << idx);

  seg_hex_glyph u_glyph (
    .nibble (nibble),
    .seg    (seg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      frame_done <= wrap;
      if (slot_end) idx <= wrap ? '0 : idx + 1'b1;
    end
  end

  // Display register only changes at the frame boundary; a load landing
  // exactly on the wrap bypasses the pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val      <= '0;
      disp_dp       <= '0;
      pend_val      <= '0;
      pend_dp       <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      if (wrap) begin
        if (load) begin
          disp_val <= value;
          disp_dp  <= dp_in;
        end else if (pending_valid) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
        end
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg  <= SEG_BLANK;
      dp_n <= 1'b1;
      an   <= '1;
    end else begin
      seg  <= seg_next;
      dp_n <= ~dp_sel;
      an   <= an_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, 4-cycle slots, 1 blank cycle).
// Honours SEVSEG_LZB_EN the same way as the design.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: n counts clock edges since reset release.
  int          n;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pv;
  logic        seen_one;

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Lit segments {a,b,c,d,e,f,g} for each hex glyph.
  function automatic logic [6:0] glyph_on(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    return ~glyph_on(h);
  endfunction

  function automatic logic digit_lit(input logic [15:0] v, input logic [3:0] d, input int i);
`ifdef SEVSEG_LZB_EN
    return (i == 0) || d[i] || ((v >> (4 * i)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic chk_reset();
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_an", an, 4'hF);
    chk("rst_frame_done", frame_done, 1'b0);
  endtask

  // One clock edge with the given inputs; outputs after the edge reflect
  // the slot position and display contents from before it.
  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
    int          digit, phase;
    logic        wrap;
    logic [6:0]  exp_seg;
    logic        exp_dpn;
    logic [3:0]  exp_an;
    load  = ld;
    value = v;
    dp_in = d;
    @(posedge clk);
    digit   = (n / RD) % ND;
    phase   = n % RD;
    wrap    = ((n % FRAME) == FRAME - 1);
    exp_seg = seg_of(m_disp[4*digit +: 4]);
    exp_dpn = ~m_dp[digit];
    exp_an  = (phase < BC || !digit_lit(m_disp, m_dp, digit)) ? 4'hF : ~(4'b0001 << digit);
    if (wrap) begin
      if (ld) begin
        m_disp = v;
        m_dp   = d;
      end else if (m_pv) begin
        m_disp = m_pend;
        m_dp   = m_pdp;
      end
      m_pv = 1'b0;
    end else if (ld) begin
      m_pend = v;
      m_pdp  = d;
      m_pv   = 1'b1;
    end
    #1;
    chk("seg", seg, exp_seg);
    chk("dp_n", dp_n, exp_dpn);
    chk("an", an, exp_an);
    chk("frame_done", frame_done, wrap);
    if (seg === seg_of(4'h1)) seen_one = 1'b1;
    n++;
    load = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  // Advance until the next edge is at position r within the frame.
  task automatic run_to(input int r);
    while ((n % FRAME) != r) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic model_reset();
    n      = 0;
    m_disp = '0;
    m_pend = '0;
    m_dp   = '0;
    m_pdp  = '0;
    m_pv   = 1'b0;
  endtask

  initial begin
    model_reset();
    seen_one = 1'b0;

    // Reset state
    #12;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: blanking, digit order and frame_done spacing
    idle(64);

    // Load 0A3F with dp on digit 2, mid-frame
    run_to(2);
    step(1'b1, 16'h0A3F, 4'b0100);
    run_to(0);
    step(1'b0, 16'h0, 4'h0);
    chk("d0_glyph_F", seg, seg_of(4'hF));
    run_to(4);
    step(1'b0, 16'h0, 4'h0);
    chk("d1_glyph_3", seg, seg_of(4'h3));
    chk("d1_dp_off", dp_n, 1'b1);
    run_to(8);
    step(1'b0, 16'h0, 4'h0);
    step(1'b0, 16'h0, 4'h0);
    chk("d2_glyph_A", seg, seg_of(4'hA));
    chk("d2_dp_on", dp_n, 1'b0);
    chk("d2_an", an, 4'b1011);
    idle(20);

    // Two loads within one frame: last one wins, 1 never shown
    run_to(1);
    seen_one = 1'b0;
    step(1'b1, 16'h1111, 4'h0);
    idle(3);
    step(1'b1, 16'h2222, 4'h0);
    run_to(0);
    step(1'b0, 16'h0, 4'h0);
    chk("last_load_wins", seg, seg_of(4'h2));
    idle(FRAME * 2);
    chk("no_one_shown", seen_one, 1'b0);

    // Load exactly on the wrap edge goes straight to the display
    run_to(FRAME - 1);
    step(1'b1, 16'h0005, 4'h0);
    chk("wrap_pending_clear", dut.pending_valid, 1'b0);
    step(1'b0, 16'h0, 4'h0);
    chk("wrap_load_d0", seg, seg_of(4'h5));
    idle(FRAME);

`ifdef SEVSEG_LZB_EN
    // Leading-zero blanking
    run_to(3);
    step(1'b1, 16'h0050, 4'h0);
    run_to(0);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 16'h0, 4'h0);
      chk("lzb_upper_dark", an[3:2], 2'b11);
    end
    step(1'b1, 16'h0000, 4'h0);
    run_to(0);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 16'h0, 4'h0);
      chk("lzb_zero_upper_dark", an[3:1], 3'b111);
    end
`endif

    // Randomized loads at random spacing
    for (int k = 0; k < 24; k++) begin
      idle($urandom_range(0, 20));
      step(1'b1, 16'($urandom), 4'($urandom));
    end
    idle(FRAME * 2);

    // Asynchronous reset mid-slot of digit 2 with a load pending
    run_to(4);
    step(1'b1, 16'hBEEF, 4'hF);
    run_to(9);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    chk("rst_pending_clear", dut.pending_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    idle(FRAME * 2);
    chk("post_reset_pos", n, FRAME * 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed digits, legal range 1..16.
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot, legal range >= 2.
REQ-003 Parameter BLANK_CYC, default 16, anode-off cycles at the start of each slot, legal range 0..REFRESH_DIV-1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 value  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 rightmost.
REQ-007 dp_in  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-008 load  input  1  one-cycle strobe that captures value and dp_in.
REQ-009 seg  output  7  segments {a,b,c,d,e,f,g}, active-low.
REQ-010 dp_n  output  1  decimal point, active-low.
REQ-011 an  output  NUM_DIGITS  digit anode enables, active-low, at most one low at a time.
REQ-012 frame_done  output  1  one-cycle pulse when the last digit slot ends.

Function
REQ-013 Prescaler shall count 0..REFRESH_DIV-1 and wrap; the terminal count shall be the slot end.
REQ-014 Digit index shall advance by 1 at each slot end and wrap NUM_DIGITS-1 -> 0.
REQ-015 frame_done shall be 1 for exactly the cycle after the slot end at which index wraps to 0.
REQ-016 load shall write value/dp_in into a pending register and set pending_valid.
REQ-017 At each index wrap, the display register shall take pending if pending_valid, then clear pending_valid; updates shall never occur mid-frame.
REQ-018 If load coincides with a wrap, the data presented with load shall go directly to the display register, and pending_valid shall end 0.
REQ-019 Back-to-back loads within one frame: the last one wins.
REQ-020 Glyphs: 0-9 standard; A, b, C, d, E, F for 10-15; all 7 segments driven per glyph.
REQ-021 seg, dp_n and an shall be registered and reflect the current index and display register one cycle later.
REQ-022 While prescaler < BLANK_CYC, an shall be all-ones; seg and dp_n shall still show the current digit.
REQ-023 NUM_DIGITS=1: index constant 0, frame_done pulses at every slot end.

Reset
REQ-024 On rst_n low: seg=7'h7F, dp_n=1, an all-ones, frame_done=0, index=0, prescaler=0, display and pending registers=0, pending_valid=0.
REQ-025 Reset mid-frame shall discard pending data; after release, scanning restarts at digit 0 with prescaler 0.

Configuration
REQ-026 Macro SEVSEG_LZB_EN defined: leading-zero blanking; digits above the most significant nonzero nibble of the display register keep an high; digit 0 is always lit; a set dp bit shall keep its digit lit.
REQ-027 SEVSEG_LZB_EN undefined: all NUM_DIGITS digits shall be lit in their slots.

Structure
REQ-028 Shared package seg_pkg shall hold the 16-entry glyph table constants, SEG_BLANK=7'h7F, and the digit-index width function clog2-based.
REQ-029 Sub-module seg_hex_glyph shall be the combinational nibble-to-active-low-segment lookup, instantiated once on the muxed nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1 unless stated)
REQ-030 Reset, then idle 64 cycles -> an cycles 1110,1101,1011,0111 with each digit low 3 of 4 cycles and all-ones 1 cycle; frame_done pulses every 16 cycles.
REQ-031 load value=16'h0A3F, dp_in=4'b0100 -> after next frame_done, digit0 seg=~7'b1000111, digit1 seg=~7'b1111001, digit2 seg=~7'b1110111, dp_n=0 only on digit2.
REQ-032 Two loads (16'h1111 then 16'h2222) within one frame -> the next frame shows only 2s; no 1 is ever displayed.
REQ-033 load asserted in the exact wrap cycle with 16'h0005 -> the frame starting then shows 5 on digit 0; pending_valid=0 afterwards.
REQ-034 SEVSEG_LZB_EN defined, value=16'h0050 -> digits 3 and 2 never drive an low; digits 1 and 0 are lit; value=16'h0000 -> only digit 0 is lit, showing 0.
REQ-035 rst_n pulsed low mid-slot of digit 2 with a load pending -> outputs go to reset values asynchronously; after release, scanning restarts at digit 0 showing 0.
